donut_shade: RTL

DONUT_SHADE -- requirements
Module: donut_shade

---
 rtl/donut_shade_if.sv | 22 ++
 rtl/donut_shade.sv | 128 ++++++++++++
 2 files changed

// File: rtl/donut_shade_if.sv
// Pixel-stream bundle between the raster/renderer front end and the donut shader.
// The slave side is the shader: beam position and donut sample in, colour and frame count out.
interface donut_shade_if;
    logic [10:0] i_h_count;
    logic [9:0]  i_v_count;
    logic        i_donut_visible;
    logic [5:0]  i_donut_luma;
    logic [1:0]  o_vga_r;
    logic [1:0]  o_vga_g;
    logic [1:0]  o_vga_b;
    logic [7:0]  o_fcount;

    modport master (
        output i_h_count, i_v_count, i_donut_visible, i_donut_luma,
        input  o_vga_r, o_vga_g, o_vga_b, o_fcount
    );

    modport slave (
        input  i_h_count, i_v_count, i_donut_visible, i_donut_luma,
        output o_vga_r, o_vga_g, o_vga_b, o_fcount
    );
endinterface

// File: rtl/donut_shade.sv
// Two-stage shader: fades the donut luma in over the first 64 frames, Bayer-dithers it
// to 2-bit grey, and fills the non-donut area with a scrolling blue stripe pattern.
module donut_shade #(
    parameter int H_DISPLAY = 1220,
    parameter int H_TOTAL   = 1525,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 525
) (
    input logic          clk,
    input logic          rst,
    donut_shade_if.slave bus
);

    logic [7:0]  r_fcount;
    logic [6:0]  r_fade;

    logic        r_display_on;
    logic        r_visible;
    logic [5:0]  r_faded;
    logic        r_h_bit8;
    logic [1:0]  r_px;
    logic [5:0]  r_v_low;

    logic [1:0]  r_vga_r;
    logic [1:0]  r_vga_g;
    logic [1:0]  r_vga_b;

    logic        w_eof;
    logic        w_display_on;
    logic [11:0] w_product;
    logic [5:0]  w_faded;
    logic [3:0]  w_thresh;
    logic        w_bump;
    logic [2:0]  w_sum;
    logic [1:0]  w_level;
    logic [5:0]  w_vb;
    logic        w_stripe;

    assign w_eof        = (bus.i_h_count == 11'(H_TOTAL - 1)) && (bus.i_v_count == 10'(V_TOTAL - 1));
    assign w_display_on = (bus.i_h_count < 11'(H_DISPLAY)) && (bus.i_v_count < 10'(V_DISPLAY));

    // fade <= 64 and luma <= 63, so the product fits 12 bits and the shifted result fits 6.
    assign w_product = 12'(bus.i_donut_luma) * 12'(r_fade);
    assign w_faded   = 6'(w_product >> 6);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcount <= '0;
            r_fade   <= '0;
        end else if (w_eof) begin
            r_fcount <= r_fcount + 8'd1;
            if (r_fade < 7'd64) begin
                r_fade <= r_fade + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_display_on <= 1'b0;
            r_visible    <= 1'b0;
            r_faded      <= '0;
            r_h_bit8     <= 1'b0;
            r_px         <= '0;
            r_v_low      <= '0;
        end else begin
            r_display_on <= w_display_on;
            r_visible    <= bus.i_donut_visible;
            r_faded      <= w_faded;
            r_h_bit8     <= bus.i_h_count[8];
            r_px         <= bus.i_h_count[4:3];
            r_v_low      <= bus.i_v_count[5:0];
        end
    end

    always_comb begin
        w_thresh = 4'd0;
        case ({r_v_low[1:0], r_px})
            4'b00_00: w_thresh = 4'd0;
            4'b00_01: w_thresh = 4'd8;
            4'b00_10: w_thresh = 4'd2;
            4'b00_11: w_thresh = 4'd10;
            4'b01_00: w_thresh = 4'd12;
            4'b01_01: w_thresh = 4'd4;
            4'b01_10: w_thresh = 4'd14;
            4'b01_11: w_thresh = 4'd6;
            4'b10_00: w_thresh = 4'd3;
            4'b10_01: w_thresh = 4'd11;
            4'b10_10: w_thresh = 4'd1;
            4'b10_11: w_thresh = 4'd9;
            4'b11_00: w_thresh = 4'd15;
            4'b11_01: w_thresh = 4'd7;
            4'b11_10: w_thresh = 4'd13;
            4'b11_11: w_thresh = 4'd5;
            default:  w_thresh = 4'd0;
        endcase
    end

    assign w_bump  = (r_faded[3:0] > w_thresh);
    assign w_sum   = {1'b0, r_faded[5:4]} + {2'b00, w_bump};
    assign w_level = w_sum[2] ? 2'd3 : w_sum[1:0];

    // Only bit 5 of (v + fcount) matters, and it depends only on the low six bits of each.
    assign w_vb     = r_v_low + r_fcount[5:0];
    assign w_stripe = r_h_bit8 ^ 1'(w_vb >> 5);

    always_ff @(posedge clk) begin
        if (rst || !r_display_on) begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
        end else if (r_visible) begin
            r_vga_r <= w_level;
            r_vga_g <= w_level;
            r_vga_b <= w_level;
        end else begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= {1'b0, w_stripe};
        end
    end

    assign bus.o_vga_r  = r_vga_r;
    assign bus.o_vga_g  = r_vga_g;
    assign bus.o_vga_b  = r_vga_b;
    assign bus.o_fcount = r_fcount;

endmodule
